// File: rtl/move_recorder.sv
// move_recorder: debounces the push-buttons and records the move sequence as a packed order vector.
// Ports: clk, rst_n (async, active-low); btn[4:0] raw buttons {UNDO,RIGHT,LEFT,DOWN,UP};
//        finish closes the sequence; ord (2 bits per move), cnt (move count), comp (sequence closed),
//        push (move appended pulse), ovf (direction rejected pulse).
module move_recorder #(
    parameter int DEB_CYCLES = 3000,
    parameter int MAX_MOVES  = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  btn,
    input  logic        finish,
    output logic [43:0] ord,
    output logic [25:0] cnt,
    output logic        comp,
    output logic        push,
    output logic        ovf
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [4:0] MAX = 5'(MAX_MOVES);
    typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;
    state_t state_q, state_d;
    logic [4:0] sync1_q, sync2_q;
    logic [4:0] vec_q, vec_d;
    logic [DW-1:0] deb_q, deb_d, deb_inc;
    logic fire;
    logic [43:0] ord_q, ord_d;
    logic [4:0] cnt_q, cnt_d;
    logic comp_q, comp_d, push_q, push_d, ovf_q, ovf_d;
    logic [1:0] code;
    logic [5:0] wr_idx, un_idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            vec_q   <= '0;
            deb_q   <= '0;
            ord_q   <= '0;
            cnt_q   <= '0;
            comp_q  <= 1'b0;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            state_q <= state_d;
            vec_q   <= vec_d;
            deb_q   <= deb_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
            comp_q  <= comp_d;
            push_q  <= push_d;
            ovf_q   <= ovf_d;
        end
    end
    // Debounce FSM: a press fires once after DEB_CYCLES identical samples; re-arming needs DEB_CYCLES zero samples.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        deb_d   = deb_q;
        fire    = 1'b0;
        deb_inc = deb_q + DW'(1);
        case (state_q)
            IDLE: if (sync2_q != '0) begin
                vec_d   = sync2_q;
                deb_d   = '0;
                state_d = DEB;
            end
            DEB: if (sync2_q == '0) begin
                state_d = IDLE;
            end else if (sync2_q != vec_q) begin
                vec_d = sync2_q;
                deb_d = '0;
            end else begin
                deb_d = deb_inc;
                if (deb_inc == DEB_LAST) begin
                    fire    = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: if (sync2_q == '0) begin
                deb_d   = '0;
                state_d = REL;
            end
            REL: if (sync2_q != '0) begin
                state_d = HELD;
            end else begin
                deb_d = deb_inc;
                if (deb_inc == DEB_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Move store: UNDO beats every direction; UNDO also beats a comp set requested in the same cycle.
    always_comb begin
        ord_d  = ord_q;
        cnt_d  = cnt_q;
        push_d = 1'b0;
        ovf_d  = 1'b0;
        comp_d = comp_q | finish | (cnt_q == MAX);
        code   = vec_q[0] ? 2'b01 : vec_q[1] ? 2'b11 : vec_q[2] ? 2'b00 : 2'b10;
        wr_idx = {cnt_q, 1'b0};
        un_idx = {cnt_q - 5'd1, 1'b0};
        if (fire) begin
            if (vec_q[4]) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 5'd1;
                    ord_d[un_idx +: 2] = 2'b00;
                    comp_d = 1'b0;
                end
            end else if (comp_q || cnt_q == MAX) begin
                ovf_d = 1'b1;
            end else begin
                ord_d[wr_idx +: 2] = code;
                cnt_d  = cnt_q + 5'd1;
                push_d = 1'b1;
            end
        end
    end
    assign ord  = ord_q;
    assign cnt  = {21'd0, cnt_q};
    assign comp = comp_q;
    assign push = push_q;
    assign ovf  = ovf_q;
endmodule
